difftest_step_batcher: RTL and testbench

//  Sits between SimTop.difftest_step and the testbench DPI caller.
//  - Accumulates per-cycle commit counts into batches; queues closed batches in a small FIFO.
//  - The testbench pops one batch per handshake and issues a single simv_nstep() for it.
//  - Cuts DPI call rate without losing steps, and reports back-pressure loss.

---
 rtl/difftest_step_batcher.sv | 162 ++++++++++++++++
 tb/tb_difftest_step_batcher.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into closed batches queued for the DPI caller.
// Optional trace output: define DIFFTEST_BATCH_TRACE_EN.
module difftest_step_batcher #(
    parameter int STEP_WIDTH = 8,
    parameter int SUM_WIDTH  = 16,
    parameter int MAX_BATCH  = 64,
    parameter int TIMEOUT    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [STEP_WIDTH-1:0] in_step,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_WIDTH-1:0]  out_nstep,
    output logic [63:0]           out_cycle,
    output logic                  busy,
    output logic                  overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_STALL
    } state_t;

    state_t                 r_state;
    logic [SUM_WIDTH-1:0]   r_acc;
    logic [IW-1:0]          r_idle_cnt;
    logic [63:0]            r_n_cycles;
    logic                   r_overflow;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [PW:0]            r_count;
    logic [SUM_WIDTH-1:0]   r_nstep_mem [FIFO_DEPTH];
    logic [63:0]            r_cycle_mem [FIFO_DEPTH];

    logic [SUM_WIDTH:0]     w_sum_raw;
    logic                   w_sat;
    logic [SUM_WIDTH-1:0]   w_sum;
    logic                   w_close_req;
    logic                   w_timeout;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_can_push;
    logic                   w_push;

    assign w_sum_raw = {1'b0, r_acc}
                     + {{(SUM_WIDTH + 1 - STEP_WIDTH){1'b0}}, in_step};
    assign w_sat     = w_sum_raw[SUM_WIDTH];
    assign w_sum     = w_sat ? '1 : w_sum_raw[SUM_WIDTH-1:0];

    assign w_timeout = (r_idle_cnt == IW'(TIMEOUT - 1))
                     & (in_step == '0) & (r_acc != '0);
    assign w_close_req = (w_sum >= SUM_WIDTH'(MAX_BATCH))
                       | w_timeout
                       | (flush & (w_sum != '0));

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PW + 1)'(FIFO_DEPTH));
    assign w_pop      = out_valid & out_ready;
    assign w_can_push = !w_full | w_pop;
    // A stalled batch is already closed; it only waits for room.
    assign w_push     = (r_state == S_STALL) ? w_can_push
                                             : (w_close_req & w_can_push);

    assign out_valid = !w_empty;
    assign out_nstep = w_empty ? '0 : r_nstep_mem[r_rptr];
    assign out_cycle = w_empty ? '0 : r_cycle_mem[r_rptr];
    assign busy      = (r_acc != '0) | out_valid;
    assign overflow  = r_overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_idle_cnt <= '0;
            r_n_cycles <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_n_cycles <= r_n_cycles + 64'd1;
            if (w_sat) r_overflow <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_close_req) begin
                        if (!w_can_push) begin
                            r_acc   <= w_sum;
                            r_state <= S_STALL;
                        end
                    end else if (w_sum != '0) begin
                        r_acc      <= w_sum;
                        r_idle_cnt <= '0;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_close_req && w_can_push) begin
                        r_acc      <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (w_close_req) begin
                        r_acc   <= w_sum;
                        r_state <= S_STALL;
                    end else begin
                        r_acc      <= w_sum;
                        r_idle_cnt <= (in_step == '0) ? r_idle_cnt + IW'(1)
                                                      : '0;
                    end
                end
                S_STALL: begin
                    if (w_can_push) begin
                        r_acc      <= '0;
                        r_idle_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are masked by the empty flag.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_nstep_mem[r_wptr] <= w_sum;
            r_cycle_mem[r_wptr] <= r_n_cycles;
        end
    end

`ifdef DIFFTEST_BATCH_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset && w_push)
            $display("[BATCH] cycle=%0d nstep=%0d", r_n_cycles, w_sum);
        if (!reset && w_sat && !r_overflow)
            $display("[BATCH] OVERFLOW cycle=%0d", r_n_cycles);
    end
`endif

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Randomised and directed bench for difftest_step_batcher.
// Expected values come from a queue-based batch model.
module tb_difftest_step_batcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_step = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_nstep;
    logic [63:0] out_cycle;
    logic        busy;
    logic        overflow;

    difftest_step_batcher dut (
        .clock     (clock),
        .reset     (reset),
        .in_step   (in_step),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_nstep (out_nstep),
        .out_cycle (out_cycle),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned     n;
        longint unsigned c;
    } ent_t;

    ent_t            mq[$];
    int unsigned     m_acc;
    int unsigned     m_zeros;
    bit              m_pending;
    bit              m_ovf;
    longint unsigned m_cyc;
    int unsigned     seen[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_acc = 0;
        m_zeros = 0;
        m_pending = 0;
        m_ovf = 0;
        m_cyc = 0;
    endtask

    // One clock edge of batching: close on threshold, idle timeout or flush.
    task automatic model_edge(input int unsigned step, input bit fl,
                              input bit rdy);
        int unsigned sum;
        bit pop, room, want;
        ent_t e;
        sum = m_acc + step;
        if (sum > 65535) begin
            sum = 65535;
            m_ovf = 1;
        end
        pop  = (mq.size() > 0) && rdy;
        room = (mq.size() < 4) || pop;
        want = m_pending || (sum >= 64)
            || (m_zeros == 15 && step == 0 && m_acc != 0)
            || (fl && sum != 0);
        if (pop) void'(mq.pop_front());
        if (want && room) begin
            e.n = sum;
            e.c = m_cyc;
            mq.push_back(e);
            m_acc = 0;
            m_zeros = 0;
            m_pending = 0;
        end else if (want) begin
            m_acc = sum;
            m_pending = 1;
        end else begin
            m_zeros = (step == 0 && m_acc != 0) ? m_zeros + 1 : 0;
            m_acc = sum;
        end
        m_cyc++;
    endtask

    task automatic compare_outputs();
        bit v;
        v = mq.size() > 0;
        check("valid", out_valid, v);
        check("nstep", out_nstep, v ? mq[0].n : 0);
        check("cycle", out_cycle, v ? mq[0].c : 0);
        check("busy", busy, (m_acc != 0) || v);
        check("ovf", overflow, m_ovf);
    endtask

    task automatic tick(input int unsigned step, input bit fl, input bit rdy);
        in_step = 8'(step);
        flush = fl;
        out_ready = rdy;
        #1;
        compare_outputs();
        if (rdy && out_valid) seen.push_back(out_nstep);
        model_edge(step, fl, rdy);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_step = 8'd3;
        flush = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (5) begin
            @(negedge clock);
            check("rst_valid", out_valid, 0);
            check("rst_nstep", out_nstep, 0);
            check("rst_cycle", out_cycle, 0);
            check("rst_busy", busy, 0);
            check("rst_ovf", overflow, 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        int unsigned r;
        do_reset();
        repeat (20) tick(0, 0, 0);

        do_reset();
        repeat (8) tick(8, 0, 1);
        check("thr_nstep", out_nstep, 64);
        check("thr_cycle", out_cycle, 7);
        tick(0, 0, 1);
        check("thr_busy", busy, 0);

        tick(5, 0, 0);
        repeat (15) tick(0, 0, 0);
        check("to_early", out_valid, 0);
        tick(0, 0, 0);
        check("to_valid", out_valid, 1);
        check("to_nstep", out_nstep, 5);
        check("to_busy", busy, 1);
        tick(0, 0, 1);
        check("to_busy_pop", busy, 0);

        tick(2, 0, 1);
        tick(2, 0, 1);
        tick(2, 1, 1);
        check("fl_nstep", out_nstep, 6);
        tick(0, 1, 1);
        check("fl_empty", out_valid, 0);
        check("fl_busy", busy, 0);

        repeat (4) tick(64, 0, 0);
        repeat (300) tick(255, 0, 0);
        check("bp_ovf", overflow, 1);
        check("bp_busy", busy, 1);
        seen.delete();
        repeat (8) tick(0, 0, 1);
        check("bp_npop", seen.size(), 5);
        for (int i = 0; i < 4; i++)
            check("bp_pop64", (seen.size() > i) ? seen[i] : 0, 64);
        check("bp_popsat", (seen.size() > 4) ? seen[4] : 0, 65535);

        do_reset();
        repeat (4) tick(64, 0, 0);
        tick(64, 0, 1);
        check("pp_valid", out_valid, 1);
        seen.delete();
        repeat (6) tick(0, 0, 1);
        check("pp_npop", seen.size(), 4);
        check("pp_busy", busy, 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            tick((r < 4) ? 0 : (r < 8) ? $urandom_range(1, 12)
                                       : $urandom_range(13, 255),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1);
        end

        repeat (3) tick(10, 0, 0);
        repeat (3) tick(64, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_nstep", out_nstep, 0);
        do_reset();
        repeat (10) tick(7, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
